// File: rtl/div_sequencer_pkg.sv
// Shared ALU selector/sign encodings and the divider sequencer state type.
package div_sequencer_pkg;

  localparam int unsigned DIV_XLEN = 32;

  typedef logic [DIV_XLEN-1:0] UIntX;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
    ALU_SRA, ALU_SLT, ALU_SLTU, ALU_MUL, ALU_DIV, ALU_REM
  } AluSel;

  typedef enum logic {
    OP_UNSIGNED,
    OP_SIGNED
  } SignSel;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIX,
    DIV_DONE
  } DivState;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring divide iteration on magnitudes.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] rem_sh;

  // rem_in < divisor always holds, so the post-subtract value fits XLEN bits
  always_comb begin
    rem_sh  = {rem_in, quo_in[XLEN-1]};
    quo_out = {quo_in[XLEN-2:0], 1'b0};
    rem_out = rem_sh[XLEN-1:0];
    if (rem_sh >= {1'b0, divisor}) begin
      rem_out    = rem_sh[XLEN-1:0] - divisor;
      quo_out[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle sequencer for the EXE-stage divider: setup, XLEN restoring
// iterations, sign fix-up and result hold with kill/flush abort.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            kill,
  input  logic            req_valid,
  output logic            req_ready,
  input  AluSel           req_sel,
  input  SignSel          req_sign,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  DivState          state, next_state;
  AluSel            sel_q;
  logic             neg_q, neg_r;
  logic [XLEN-1:0]  rem_q, quo_q, dvsr_q;
  logic [XLEN-1:0]  rem_nxt, quo_nxt;
  logic [CNT_W-1:0] cnt_q;

  logic             accept, signed_op, sel_ok, is_special;
  logic [XLEN-1:0]  special_res, abs_op1, abs_op2, quo_fix, rem_fix;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvsr_q),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  always_comb begin
    signed_op = (req_sign == OP_SIGNED);
    sel_ok    = (req_sel == ALU_DIV) || (req_sel == ALU_REM);
    abs_op1   = (signed_op && req_op1[XLEN-1]) ? -req_op1 : req_op1;
    abs_op2   = (signed_op && req_op2[XLEN-1]) ? -req_op2 : req_op2;
    accept    = req_valid && (state == DIV_IDLE) && !kill;
    quo_fix   = neg_q ? -quo_q : quo_q;
    rem_fix   = neg_r ? -rem_q : rem_q;
  end

  // Cases resolved at accept time, bypassing the iteration entirely
  always_comb begin
    special_res = '0;
    is_special  = 1'b1;
    if (!sel_ok) begin
      special_res = '0;
    end else if (req_op2 == '0) begin
      special_res = (req_sel == ALU_DIV) ? '1 : req_op1;
    end else if (signed_op && req_op1 == {1'b1, {(XLEN-1){1'b0}}} && req_op2 == '1) begin
      special_res = (req_sel == ALU_DIV) ? req_op1 : '0;
    end else begin
      is_special = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DIV_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      DIV_IDLE: if (req_valid) next_state = is_special ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt_q == '0) next_state = DIV_FIX;
      DIV_FIX:  next_state = DIV_DONE;
      DIV_DONE: if (resp_ready) next_state = DIV_IDLE;
      default:  next_state = DIV_IDLE;
    endcase
    if (kill) next_state = DIV_IDLE;
  end

  always_comb begin
    req_ready = (state == DIV_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q       <= ALU_ADD;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      cnt_q       <= '0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
    end else begin
      resp_valid <= (next_state == DIV_DONE);
      if (accept) begin
        sel_q  <= req_sel;
        neg_q  <= signed_op && (req_op1[XLEN-1] ^ req_op2[XLEN-1]);
        neg_r  <= signed_op && req_op1[XLEN-1];
        rem_q  <= '0;
        quo_q  <= abs_op1;
        dvsr_q <= abs_op2;
        cnt_q  <= CNT_W'(XLEN-1);
        if (is_special) resp_result <= special_res;
      end else if (state == DIV_CALC && !kill) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q - 1'b1;
      end else if (state == DIV_FIX && !kill) begin
        resp_result <= (sel_q == ALU_DIV) ? quo_fix : rem_fix;
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed requests push expected result
// and arrival cycle; a negedge monitor checks each response as it appears.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset, kill, req_valid, req_ready, resp_valid, resp_ready;
  AluSel       req_sel;
  SignSel      req_sign;
  logic [31:0] req_op1, req_op2, resp_result;

  typedef struct {
    logic [31:0] res;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_vec = 0, n_bad = 0;
  int unsigned n_resp = 0, exp_nresp = 0;
  logic        prev_v = 1'b0;
  logic [31:0] held = '0;

  div_sequencer #(.XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .kill        (kill),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_sel     (req_sel),
    .req_sign    (req_sign),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (resp_valid && !prev_v) begin
        exp_t e;
        n_resp++;
        n_vec++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_resp got %h at cycle %0d, expected no response", resp_result, cyc);
        end else begin
          e = sb.pop_front();
          if (resp_result !== e.res || cyc != e.at) begin
            n_bad++;
            $display("FAIL resp got %h at cycle %0d, expected %h at cycle %0d", resp_result, cyc, e.res, e.at);
          end
        end
        held = resp_result;
      end else if (resp_valid && prev_v) begin
        n_vec++;
        if (resp_result !== held) begin
          n_bad++;
          $display("FAIL hold_stable got %h expected %h", resp_result, held);
        end
      end
      prev_v = resp_valid;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // lat: cycle of resp_valid relative to accept cycle T (1 special, 34 iterative)
  task automatic issue(input AluSel s, input SignSel g, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int unsigned lat);
    int unsigned w = 0;
    @(negedge clk);
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL req_ready_timeout got 0 expected 1");
      return;
    end
    req_valid = 1'b1;
    req_sel   = s;
    req_sign  = g;
    req_op1   = a;
    req_op2   = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    sb.push_back('{res: exp, at: cyc + lat - 1});
    exp_nresp++;
  endtask

  task automatic drain();
    int unsigned w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", sb.size(), 0);
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    kill       = 1'b0;
    req_valid  = 1'b0;
    req_sel    = ALU_ADD;
    req_sign   = OP_UNSIGNED;
    req_op1    = '0;
    req_op2    = '0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset_resp_result", resp_result, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);

    issue(ALU_DIV, OP_UNSIGNED, 32'd100, 32'd7, 32'd14, 34);
    issue(ALU_REM, OP_UNSIGNED, 32'd100, 32'd7, 32'd2, 34);
    issue(ALU_DIV, OP_SIGNED, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    issue(ALU_REM, OP_SIGNED, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    issue(ALU_DIV, OP_SIGNED, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    issue(ALU_REM, OP_SIGNED, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    issue(ALU_DIV, OP_SIGNED, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 34);
    issue(ALU_REM, OP_SIGNED, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 34);
    drain();

    issue(ALU_DIV, OP_UNSIGNED, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    issue(ALU_REM, OP_UNSIGNED, 32'd5, 32'd0, 32'd5, 1);
    issue(ALU_DIV, OP_SIGNED, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    issue(ALU_REM, OP_SIGNED, 32'd5, 32'd0, 32'd5, 1);
    issue(ALU_DIV, OP_SIGNED, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    issue(ALU_REM, OP_SIGNED, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    issue(ALU_DIV, OP_UNSIGNED, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
    issue(ALU_REM, OP_UNSIGNED, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
    issue(ALU_ADD, OP_UNSIGNED, 32'd5, 32'd3, 32'd0, 1);
    drain();

    // kill during CALC cycle T+10
    issue(ALU_DIV, OP_UNSIGNED, 32'd1000, 32'd3, 32'd333, 34);
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    chk("kill_req_ready", {31'b0, req_ready}, 32'd1);
    chk("kill_resp_valid", {31'b0, resp_valid}, 32'd0);
    void'(sb.pop_back());
    exp_nresp--;
    issue(ALU_DIV, OP_UNSIGNED, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 34);
    drain();

    // kill beats a same-cycle accept in IDLE
    @(negedge clk);
    req_valid = 1'b1;
    kill      = 1'b1;
    req_sel   = ALU_DIV;
    req_sign  = OP_UNSIGNED;
    req_op1   = 32'd10;
    req_op2   = 32'd2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    kill      = 1'b0;
    chk("kill_idle_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (40) @(negedge clk);

    // consumer stalls for 5 cycles in DONE
    resp_ready = 1'b0;
    issue(ALU_DIV, OP_UNSIGNED, 32'd1000, 32'd10, 32'd100, 34);
    begin
      int unsigned w = 0;
      while (!resp_valid && w < 60) begin
        @(negedge clk);
        w++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("handshake_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("handshake_req_ready", {31'b0, req_ready}, 32'd1);
    drain();

    // asynchronous reset mid-CALC
    issue(ALU_REM, OP_UNSIGNED, 32'd12345, 32'd100, 32'd45, 34);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("areset_req_ready", {31'b0, req_ready}, 32'd1);
    void'(sb.pop_back());
    exp_nresp--;
    @(negedge clk);
    reset = 1'b0;
    repeat (45) @(negedge clk);

    issue(ALU_REM, OP_UNSIGNED, 32'd12345, 32'd100, 32'd45, 34);
    drain();

    chk("response_count", n_resp, exp_nresp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
